// File: rtl/freq_meter.sv
// freq_meter
//   Measures edge count and high time of a slow asynchronous input over a
//   fixed window of GATE_CYCLES clock_i cycles. Windows run back-to-back
//   while enable_i is high; dropping enable_i mid-window discards the
//   partial window.
//
// Ports
//   clock_i   system clock, all logic on rising edge
//   reset_i   asynchronous active-high reset
//   signal_i  signal under measurement, asynchronous to clock_i
//   enable_i  level: 1 = measure continuously, 0 = idle/abort
//   edges_o   rising edges in last completed window
//   high_o    clock_i cycles signal was high in last completed window
//   stuck_o   last completed window saw no rising edge
//   level_o   synchronized signal level at end of last window
//   valid_o   one-cycle pulse when results update
//   busy_o    measurement window in progress
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 100000000,
  parameter int unsigned COUNT_WIDTH = 28
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   signal_i,
  input  logic                   enable_i,
  output logic [COUNT_WIDTH-1:0] edges_o,
  output logic [COUNT_WIDTH-1:0] high_o,
  output logic                   stuck_o,
  output logic                   level_o,
  output logic                   valid_o,
  output logic                   busy_o
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] GATE_LAST = COUNT_WIDTH'(GATE_CYCLES - 1);

  state_t state, state_next;

  logic s1, s2, s3;
  logic rise, hi;

  logic [COUNT_WIDTH-1:0] gate_cnt, edge_cnt, high_cnt;
  logic [COUNT_WIDTH-1:0] edge_sum, high_sum;

  logic clear, count, report;

  // Front end: two-flop synchronizer plus one delay flop for edge detect.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= signal_i;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign hi   = s2;

  // Totals including the current cycle, so the window-end cycle is counted.
  assign edge_sum = edge_cnt + COUNT_WIDTH'(rise);
  assign high_sum = high_cnt + COUNT_WIDTH'(hi);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    clear      = 1'b0;
    count      = 1'b0;
    report     = 1'b0;
    case (state)
      IDLE: begin
        clear = 1'b1;
        if (enable_i) state_next = MEASURE;
      end
      MEASURE: begin
        // Window end takes priority over abort: a window whose last cycle
        // coincides with enable_i falling still reports.
        if (gate_cnt == GATE_LAST) begin
          report     = 1'b1;
          clear      = 1'b1;
          state_next = enable_i ? MEASURE : IDLE;
        end else if (!enable_i) begin
          clear      = 1'b1;
          state_next = IDLE;
        end else begin
          count = 1'b1;
        end
      end
      default: begin
        clear      = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      high_cnt <= '0;
    end else if (clear) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      high_cnt <= '0;
    end else if (count) begin
      gate_cnt <= gate_cnt + 1'b1;
      edge_cnt <= edge_sum;
      high_cnt <= high_sum;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      edges_o <= '0;
      high_o  <= '0;
      stuck_o <= 1'b0;
      level_o <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= report;
      if (report) begin
        edges_o <= edge_sum;
        high_o  <= high_sum;
        stuck_o <= (edge_sum == '0);
        level_o <= s2;
      end
    end
  end

  assign busy_o = (state == MEASURE);

endmodule

// File: tb/tb_freq_meter.sv
module tb_freq_meter;

  localparam int unsigned GATE = 20;
  localparam int unsigned CW   = 8;

  localparam int M_ZERO  = 0;
  localparam int M_ONE   = 1;
  localparam int M_SQ4   = 2;
  localparam int M_P5    = 3;
  localparam int M_PULSE = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sig = 1'b0;
  logic          en  = 1'b0;
  logic [CW-1:0] edges, high;
  logic          stuck, level, valid, busy;

  freq_meter #(.GATE_CYCLES(GATE), .COUNT_WIDTH(CW)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .signal_i(sig),
    .enable_i(en),
    .edges_o (edges),
    .high_o  (high),
    .stuck_o (stuck),
    .level_o (level),
    .valid_o (valid),
    .busy_o  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int edges;
    int high;
    int stuck;
    int level;
    int gap;   // required cycles since previous valid, 0 = not checked
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   ph     = 0;
  int   pulse_at = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic pat(input int mode, input int p);
    case (mode)
      M_ONE:   return 1'b1;
      M_SQ4:   return (p % 4) >= 2;
      M_P5:    return (p % 5) == 0;
      M_PULSE: return p == pulse_at;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(input int e, input int h, input int s, input int l, input int g);
    exp_t x;
    x.edges = e; x.high = h; x.stuck = s; x.level = l; x.gap = g;
    sb.push_back(x);
  endtask

  // One iteration per cycle: inputs change on the falling edge.
  task automatic cycles(input int mode, input int n, input logic en_v);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sig = pat(mode, ph);
      en  = en_v;
      ph++;
    end
  endtask

  // Monitor: every valid pulse is matched against the scoreboard head.
  int last_v = 0;
  always @(negedge clk) begin
    if (!rst && valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("edges_o", int'(edges), x.edges);
        check("high_o",  int'(high),  x.high);
        check("stuck_o", int'(stuck), x.stuck);
        check("level_o", int'(level), x.level);
        if (x.gap != 0) check("valid_gap", cyc - last_v, x.gap);
      end
      last_v = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_edges", int'(edges), 0);
    check("rst_high",  int'(high),  0);
    check("rst_stuck", int'(stuck), 0);
    check("rst_level", int'(level), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_busy",  int'(busy),  0);
    @(negedge clk);
    rst = 1'b0;

    // 1: square wave period 4, two back-to-back windows
    ph = 0;
    cycles(M_SQ4, 8, 1'b0);
    push(5, 10, 0, 1, 0);
    push(5, 10, 0, 1, 20);
    cycles(M_SQ4, 50, 1'b1);
    cycles(M_SQ4, 4, 1'b0);

    // 2: held high, then held low
    ph = 0;
    cycles(M_ONE, 8, 1'b0);
    push(0, 20, 1, 1, 0);
    cycles(M_ONE, 30, 1'b1);
    cycles(M_ONE, 2, 1'b0);
    ph = 0;
    cycles(M_ZERO, 8, 1'b0);
    push(0, 0, 1, 0, 0);
    cycles(M_ZERO, 30, 1'b1);
    cycles(M_ZERO, 2, 1'b0);

    // 3: 1-in-5 pulses over three contiguous windows
    ph = 0;
    cycles(M_P5, 8, 1'b0);
    push(4, 4, 0, 0, 0);
    push(4, 4, 0, 0, 20);
    push(4, 4, 0, 0, 20);
    cycles(M_P5, 70, 1'b1);
    cycles(M_P5, 2, 1'b0);

    // 4: abort 10 cycles into the second window, then re-enable
    ph = 0;
    cycles(M_SQ4, 8, 1'b0);
    push(5, 10, 0, 1, 0);
    cycles(M_SQ4, 30, 1'b1);
    cycles(M_SQ4, 1, 1'b0);
    @(negedge clk);
    check("abort_busy",  int'(busy),  0);
    check("abort_valid", int'(valid), 0);
    check("abort_edges", int'(edges), 5);
    check("abort_high",  int'(high),  10);
    cycles(M_SQ4, 8, 1'b0);
    push(5, 10, 0, 0, 0);
    cycles(M_SQ4, 30, 1'b1);
    cycles(M_SQ4, 3, 1'b0);

    // 5: asynchronous reset between edges mid-window
    ph = 0;
    cycles(M_SQ4, 8, 1'b0);
    push(5, 10, 0, 1, 0);
    cycles(M_SQ4, 30, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_edges", int'(edges), 0);
    check("arst_high",  int'(high),  0);
    check("arst_stuck", int'(stuck), 0);
    check("arst_level", int'(level), 0);
    check("arst_busy",  int'(busy),  0);
    en  = 1'b0;
    sig = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ph = 0;
    pulse_at = 5;
    push(1, 1, 0, 0, 0);
    cycles(M_PULSE, 30, 1'b1);
    cycles(M_PULSE, 2, 1'b0);

    // 6a: rise on the window-end cycle; enable drops on a window end
    ph = 0;
    pulse_at = 26;
    cycles(M_PULSE, 8, 1'b0);
    push(1, 1, 0, 1, 0);
    push(0, 0, 1, 0, 20);
    cycles(M_PULSE, 40, 1'b1);
    cycles(M_PULSE, 1, 1'b0);
    @(negedge clk);
    check("wend_drop_busy", int'(busy), 0);
    cycles(M_PULSE, 3, 1'b0);

    // 6b: rise one cycle after window end
    ph = 0;
    pulse_at = 27;
    cycles(M_PULSE, 8, 1'b0);
    push(0, 0, 1, 0, 0);
    push(1, 1, 0, 0, 20);
    cycles(M_PULSE, 40, 1'b1);
    cycles(M_PULSE, 5, 1'b0);

    check("missing_valids", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
# freq_meter

Measures the frequency and duty cycle of a slow, asynchronous input, such as one of the divided clocks from the system clock divider or an external strobe, against the 100 MHz system clock. Each measurement window lasts a fixed number of system-clock cycles. At the end of the window the block reports the number of rising edges seen, the number of cycles the input was high, and a stuck flag. It sits beside the clock divider as its self-check and monitoring counterpart, and feeds the display logic.

## Interface
- GATE_CYCLES, 100000000, length of one measurement window in clock_i cycles (1 s at 100 MHz); must be ≥ 2 and < 2^COUNT_WIDTH
- COUNT_WIDTH, 28, width of the gate counter and both result counters
- clock_i  input  1  system clock, 100 MHz, all logic on rising edge
- reset_i  input  1  asynchronous, active-high reset
- signal_i  input  1  signal under measurement, asynchronous to clock_i
- enable_i  input  1  level; 1 = measure continuously, 0 = idle/abort
- edges_o  output  COUNT_WIDTH  rising edges counted in last completed window
- high_o  output  COUNT_WIDTH  clock_i cycles signal was high in last completed window
- stuck_o  output  1  last completed window had zero rising edges
- level_o  output  1  synchronized signal level at end of last window
- valid_o  output  1  one-cycle pulse: results updated this cycle
- busy_o  output  1  state is MEASURE

## Operation
- Front end runs in every state:
  - Two-flop synchronizer s1→s2, then delay flop s3.
  - rise = s2 & ~s3; hi = s2.
- States:
  - IDLE: counters held at 0; rise and hi ignored.
  - MEASURE: active measurement window.
- IDLE→MEASURE on the first clock edge where enable_i = 1.
- In MEASURE, each cycle:
  - gate_cnt increments;
  - edge_cnt += rise;
  - high_cnt += hi.
- Window end is the cycle with gate_cnt == GATE_CYCLES-1. On that clock edge:
  - edges_o ← edge_cnt + rise;
  - high_o ← high_cnt + hi;
  - stuck_o ← (edge_cnt + rise == 0);
  - level_o ← s2;
  - valid_o ← 1;
  - gate_cnt, edge_cnt and high_cnt ← 0.
- Next state after the window end: MEASURE if enable_i = 1, else IDLE.
- Windows are back-to-back with no dead cycle. Every cycle in MEASURE belongs to exactly one window.
- enable_i = 0 in MEASURE before the window end aborts the window:
  - next state IDLE, counters cleared;
  - no valid_o;
  - result outputs keep their previous values.
- If enable_i falls on the window-end cycle itself, the window completes and reports; the abort does not apply.
- Width rules:
  - edges_o ≤ ceil(GATE_CYCLES/2);
  - high_o ≤ GATE_CYCLES < 2^COUNT_WIDTH;
  - hence no overflow or saturation logic.
- Result outputs change only on a valid_o cycle.

## Timing
- Reset values:
  - all outputs 0;
  - state IDLE;
  - s1, s2, s3 and all counters 0.
- Reset asserted mid-window: immediate return to reset values; the partial window is discarded.
- Synchronizer latency:
  - signal_i first sampled high at edge k → s2 = 1 after edge k+1;
  - that rise is counted at edge k+2.
- enable_i sampled 1 at edge e → busy_o = 1 after e; the first counted cycle is the one following e.
- Window timing:
  - the first window completes GATE_CYCLES edges after entry to MEASURE;
  - valid_o is high for the cycle after that edge;
  - later valid_o pulses are exactly GATE_CYCLES cycles apart.
- A rise on the window-end cycle belongs to the ending window. A rise on the following cycle belongs to the next window.
- busy_o drops in the cycle after an abort or a final window end.

## Test plan
Sim parameters for all tests: GATE_CYCLES = 20, COUNT_WIDTH = 8.

1. Square wave, period 4 cycles, 50% duty, enable_i held 1 → every window: valid_o every 20 cycles, edges_o = 5, high_o = 10, stuck_o = 0.
2. signal_i held 1, then held 0 → high_o = 20, edges_o = 0, stuck_o = 1, level_o = 1; then high_o = 0, edges_o = 0, stuck_o = 1, level_o = 0.
3. Period 5 with 1-cycle-high pulses, continuous over 3 windows → each window edges_o = 4, high_o = 4; valid_o pulses exactly 20 cycles apart, with no gap cycles.
4. enable_i dropped after 10 cycles of a window → no valid_o; outputs keep the previous window's values; busy_o = 0 next cycle; re-enable gives a full 20-cycle window.
5. reset_i asserted asynchronously mid-window, between clock edges → outputs immediately 0; state IDLE; the first post-reset window reports only post-reset edges.
6. Single 1-cycle pulse placed so its rise lands on the window-end cycle, then so it lands one cycle later → counted in window N (edges_o = 1), then in window N+1 instead.
